mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Round-robin arbiter that lets NCORES cores share one single-port RAM.
// Each access runs IDLE -> ACCESS -> RESP: the RAM strobe (mem_en/mem_we plus
// address and write data) is driven during ACCESS, the RAM answers one cycle
// later, and that answer is passed to rdata during RESP while the winner's ack
// bit pulses for one cycle. The round-robin pointer moves to the core after the
// winner each time a new winner is picked from IDLE.
//
// Build option:
//   ARB_LOCK_EN  when defined, a granted core that holds req and lock during
//                RESP keeps the bus and goes straight back to ACCESS (2 cycles
//                per access). When undefined, lock is ignored and RESP always
//                returns to IDLE.
//
// Parameters:
//   NCORES  number of requesting cores (2..8)
//   AW      shared-memory address width
//   DW      shared-memory data width
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   req        per-core request, held until that core's ack
//   we         per-core write (1) / read (0), stable while req is high
//   addr       per-core address, core i at [i*AW +: AW]
//   wdata      per-core write data, core i at [i*DW +: DW]
//   lock       per-core bus-lock request (only with ARB_LOCK_EN)
//   gnt        one-hot grant (registered)
//   ack        one-hot, one-cycle completion pulse (registered)
//   rdata      read data, valid in the cycle ack is high
//   mem_en     RAM enable (registered)
//   mem_we     RAM write enable (registered)
//   mem_addr   RAM address (registered)
//   mem_wdata  RAM write data (registered)
//   mem_rdata  RAM read data, valid one cycle after mem_en
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int NCORES = 4,
   parameter int AW     = 16,
   parameter int DW     = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NCORES-1:0]    req,
   input  logic [NCORES-1:0]    we,
   input  logic [NCORES*AW-1:0] addr,
   input  logic [NCORES*DW-1:0] wdata,
   input  logic [NCORES-1:0]    lock,
   output logic [NCORES-1:0]    gnt,
   output logic [NCORES-1:0]    ack,
   output logic [DW-1:0]        rdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_wdata,
   input  logic [DW-1:0]        mem_rdata
);

   localparam int              PW       = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam logic [PW:0]     NC_W     = (PW+1)'(NCORES);
   localparam logic [PW-1:0]   LAST_IDX = PW'(NCORES-1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state_reg;
   logic [PW-1:0]       ptr_reg;
   logic [PW-1:0]       winner_reg;
   logic [NCORES-1:0]   gnt_reg;
   logic [NCORES-1:0]   ack_reg;
   logic                mem_en_reg;
   logic                mem_we_reg;
   logic [AW-1:0]       mem_addr_reg;
   logic [DW-1:0]       mem_wdata_reg;

   logic [AW-1:0]       addr_arr  [NCORES];
   logic [DW-1:0]       wdata_arr [NCORES];

   logic                win_found;
   logic [PW-1:0]       win_idx;
   logic [PW:0]         search_sum;
   logic [PW-1:0]       search_idx;
   logic [PW-1:0]       ptr_next;
   logic [NCORES-1:0]   win_onehot;
   logic [PW-1:0]       sel_idx;
   logic                lock_keep;

   // Unpack the flat per-core buses into indexable arrays.
   genvar gi;
   generate
      for (gi = 0; gi < NCORES; gi++) begin : g_slice
         assign addr_arr[gi]  = addr[gi*AW +: AW];
         assign wdata_arr[gi] = wdata[gi*DW +: DW];
      end
   endgenerate

   // Round-robin search: first set req bit starting at ptr_reg, wrapping
   // modulo NCORES (works for non-power-of-two core counts too).
   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      search_sum = '0;
      search_idx = '0;
      for (int k = 0; k < NCORES; k++) begin
         search_sum = {1'b0, ptr_reg} + (PW+1)'(k);
         if (search_sum >= NC_W) begin
            search_sum = search_sum - NC_W;
         end
         search_idx = search_sum[PW-1:0];
         if (!win_found && req[search_idx]) begin
            win_found = 1'b1;
            win_idx   = search_idx;
         end
      end
   end

   assign ptr_next   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
   assign win_onehot = NCORES'(1) << win_idx;

   // Source of the next RAM strobe: the fresh winner when leaving IDLE,
   // otherwise the core that already owns the bus (locked continuation).
   assign sel_idx = (state_reg == IDLE) ? win_idx : winner_reg;

`ifdef ARB_LOCK_EN
   assign lock_keep = req[winner_reg] & lock[winner_reg];
`else
   logic lock_unused;
   assign lock_unused = ^lock;
   assign lock_keep   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         winner_reg    <= '0;
         gnt_reg       <= '0;
         ack_reg       <= '0;
         mem_en_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               ack_reg <= '0;
               if (win_found) begin
                  state_reg     <= ACCESS;
                  winner_reg    <= win_idx;
                  ptr_reg       <= ptr_next;
                  gnt_reg       <= win_onehot;
                  mem_en_reg    <= 1'b1;
                  mem_we_reg    <= we[sel_idx];
                  mem_addr_reg  <= addr_arr[sel_idx];
                  mem_wdata_reg <= wdata_arr[sel_idx];
               end
            end

            ACCESS: begin
               // The RAM samples the strobe on this edge; ack lines up with
               // the cycle in which its read data appears.
               state_reg  <= RESP;
               mem_en_reg <= 1'b0;
               mem_we_reg <= 1'b0;
               ack_reg    <= gnt_reg;
            end

            RESP: begin
               ack_reg <= '0;
               if (lock_keep) begin
                  // Locked owner keeps gnt and the pointer; new operands.
                  state_reg     <= ACCESS;
                  mem_en_reg    <= 1'b1;
                  mem_we_reg    <= we[sel_idx];
                  mem_addr_reg  <= addr_arr[sel_idx];
                  mem_wdata_reg <= wdata_arr[sel_idx];
               end else begin
                  state_reg <= IDLE;
                  gnt_reg   <= '0;
               end
            end

            default: begin
               state_reg  <= IDLE;
               gnt_reg    <= '0;
               ack_reg    <= '0;
               mem_en_reg <= 1'b0;
               mem_we_reg <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = gnt_reg;
   assign ack       = ack_reg;
   assign mem_en    = mem_en_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (NCORES=4, AW=16, DW=8). A behavioural
// RAM answers the arbiter. Every expected completion (core, read data, spacing
// to the previous ack) is queued when the request is driven and popped when an
// ack appears. Scenarios: reset state, single read, write + readback,
// pointer wrap, four-way contention, reset mid-access, lock bursts.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int NC = 4;
   localparam int AW = 16;
   localparam int DW = 8;

   typedef struct {
      int        core;
      bit        wr;
      logic [7:0] data;
      int        gap;
   } exp_t;

   logic                 clk;
   logic                 reset_n;
   logic [NC-1:0]        req;
   logic [NC-1:0]        we;
   logic [NC*AW-1:0]     addr;
   logic [NC*DW-1:0]     wdata;
   logic [NC-1:0]        lock;
   logic [NC-1:0]        gnt;
   logic [NC-1:0]        ack;
   logic [DW-1:0]        rdata;
   logic                 mem_en;
   logic                 mem_we;
   logic [AW-1:0]        mem_addr;
   logic [DW-1:0]        mem_wdata;
   logic [DW-1:0]        mem_rdata;

   logic [DW-1:0]        ram [0:(1<<AW)-1];
   logic                 ld_en;
   logic [AW-1:0]        ld_addr;
   logic [DW-1:0]        ld_data;

   exp_t sb[$];
   int   total;
   int   bad;
   int   cyc;
   int   last_ack;
   int   burst_left [NC];

   mem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .lock      (lock),
      .gnt       (gnt),
      .ack       (ack),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM with a registered read and a preload port.
   always @(posedge clk) begin
      if (ld_en) begin
         ram[ld_addr] <= ld_data;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(posedge clk);
      #1;
      ld_en = 1'b0;
   endtask

   task automatic issue(input int c, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int n);
      req[c]             = 1'b1;
      we[c]              = w;
      addr[c*AW +: AW]   = a;
      wdata[c*DW +: DW]  = d;
      burst_left[c]      = n;
   endtask

   task automatic push(input int c, input bit w, input logic [7:0] d, input int g);
      exp_t e;
      e.core = c;
      e.wr   = w;
      e.data = d;
      e.gap  = g;
      sb.push_back(e);
   endtask

   // One clock: sample outputs at the falling edge, check invariants, score
   // any ack, and drop a core's request once its burst is finished.
   task automatic tick();
      exp_t e;
      int   c;
      @(negedge clk);
      cyc++;
      check("gnt_onehot", 32'($onehot0(gnt)), 1);
      check("ack_onehot", 32'($onehot0(ack)), 1);
      check("we_without_en", 32'(mem_we & ~mem_en), 0);
      if (ack != '0) begin
         c = 0;
         for (int i = 0; i < NC; i++) if (ack[i]) c = i;
         $display("ack core=%0d rdata=%02h cycle=%0d", c, rdata, cyc);
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'(ack), 0);
         end else begin
            e = sb.pop_front();
            check("ack_core", 32'(ack), 32'(1) << e.core);
            if (!e.wr) check("rdata", 32'(rdata), 32'(e.data));
            if (e.gap != 0) check("ack_gap", cyc - last_ack, e.gap);
         end
         last_ack = cyc;
         if (burst_left[c] > 0) burst_left[c]--;
         if (burst_left[c] == 0) begin
            req[c]  = 1'b0;
            lock[c] = 1'b0;
         end
      end
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while ((sb.size() != 0 || gnt != '0) && n < max) begin
         tick();
         n++;
      end
      check("drain_done", 32'(sb.size() == 0 && gnt == '0), 1);
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; last_ack = 0;
      req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
      reset_n = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      for (int i = 0; i < NC; i++) burst_left[i] = 0;

      load(16'h0010, 8'hA5);
      load(16'h0100, 8'h11);
      load(16'h0101, 8'h22);
      load(16'h0102, 8'h33);
      load(16'h0103, 8'h44);
      load(16'h0200, 8'h6D);
      load(16'h0201, 8'h7E);
      load(16'h0300, 8'h9B);
      load(16'h0301, 8'hC4);

      // Reset state
      repeat (2) tick();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_ack", 32'(ack), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      reset_n = 1'b1;
      tick();

      // Single read from core0, exact latency
      issue(0, 1'b0, 16'h0010, 8'h00, 1);
      push(0, 1'b0, 8'hA5, 0);
      tick();
      check("rd_mem_en", 32'(mem_en), 1);
      check("rd_mem_addr", 32'(mem_addr), 32'h0010);
      check("rd_mem_we", 32'(mem_we), 0);
      check("rd_gnt", 32'(gnt), 32'b0001);
      tick();
      check("rd_ack", 32'(ack), 32'b0001);
      check("rd_mem_en_off", 32'(mem_en), 0);
      tick();
      check("rd_gnt_off", 32'(gnt), 0);
      check("rd_ack_off", 32'(ack), 0);
      drain(10);

      // Write from core2, then read it back
      issue(2, 1'b1, 16'h0003, 8'h5C, 1);
      push(2, 1'b1, 8'h00, 0);
      tick();
      check("wr_mem_we", 32'(mem_we), 1);
      check("wr_mem_addr", 32'(mem_addr), 32'h0003);
      check("wr_mem_wdata", 32'(mem_wdata), 32'h5C);
      check("wr_gnt", 32'(gnt), 32'b0100);
      tick();
      check("wr_mem_we_off", 32'(mem_we), 0);
      check("wr_ack", 32'(ack), 32'b0100);
      drain(10);
      issue(2, 1'b0, 16'h0003, 8'h00, 1);
      push(2, 1'b0, 8'h5C, 0);
      drain(10);

      // Wrap: ptr=3 after core2, req=1001 -> core3 then core0 (ptr -> 1)
      issue(3, 1'b0, 16'h0200, 8'h00, 1);
      issue(0, 1'b0, 16'h0201, 8'h00, 1);
      push(3, 1'b0, 8'h6D, 0);
      push(0, 1'b0, 8'h7E, 3);
      drain(20);
      // ptr=1: req=0101 -> core2 before core0
      issue(2, 1'b0, 16'h0003, 8'h00, 1);
      issue(0, 1'b0, 16'h0010, 8'h00, 1);
      push(2, 1'b0, 8'h5C, 0);
      push(0, 1'b0, 8'hA5, 3);
      drain(20);

      // Contention: all four request from reset, core0 comes back once more
      reset_n = 1'b0;
      tick();
      issue(0, 1'b0, 16'h0100, 8'h00, 2);
      issue(1, 1'b0, 16'h0101, 8'h00, 1);
      issue(2, 1'b0, 16'h0102, 8'h00, 1);
      issue(3, 1'b0, 16'h0103, 8'h00, 1);
      push(0, 1'b0, 8'h11, 0);
      push(1, 1'b0, 8'h22, 3);
      push(2, 1'b0, 8'h33, 3);
      push(3, 1'b0, 8'h44, 3);
      push(0, 1'b0, 8'h11, 3);
      tick();
      check("hold_in_reset", 32'(gnt), 0);
      reset_n = 1'b1;
      drain(60);

      // Reset mid-access: core1 granted (ptr -> 2), reset during ACCESS
      issue(1, 1'b0, 16'h0101, 8'h00, 1);
      tick();
      check("mid_mem_en", 32'(mem_en), 1);
      check("mid_gnt", 32'(gnt), 32'b0010);
      reset_n = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(gnt), 0);
      check("mid_rst_mem_en", 32'(mem_en), 0);
      check("mid_rst_mem_addr", 32'(mem_addr), 0);
      check("mid_rst_ack", 32'(ack), 0);
      req[1] = 1'b0;
      burst_left[1] = 0;
      repeat (2) tick();
      reset_n = 1'b1;
      // ptr back at 0: core1 wins over core3
      issue(1, 1'b0, 16'h0101, 8'h00, 1);
      issue(3, 1'b0, 16'h0103, 8'h00, 1);
      push(1, 1'b0, 8'h22, 0);
      push(3, 1'b0, 8'h44, 3);
      drain(30);

      // Lock: first move ptr to 1, then core1 locked burst of 3 vs core0
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      issue(0, 1'b0, 16'h0301, 8'h00, 1);
      push(0, 1'b0, 8'hC4, 0);
      drain(20);
      issue(1, 1'b0, 16'h0300, 8'h00, 3);
      lock[1] = 1'b1;
      issue(0, 1'b0, 16'h0301, 8'h00, 1);
`ifdef ARB_LOCK_EN
      push(1, 1'b0, 8'h9B, 0);
      push(1, 1'b0, 8'h9B, 2);
      push(1, 1'b0, 8'h9B, 2);
      push(0, 1'b0, 8'hC4, 3);
`else
      push(1, 1'b0, 8'h9B, 0);
      push(0, 1'b0, 8'hC4, 3);
      push(1, 1'b0, 8'h9B, 3);
      push(1, 1'b0, 8'h9B, 3);
`endif
      drain(60);
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
